// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the pipelined ALU control decoder: alu_op classes,
// R-type funct codes, alu_sel values and the pipeline state type.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LWSW  = 4'b0010;
    localparam logic [3:0] OP_RTYPE = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_JUMP  = 4'b1111;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_ADD  = 4'b0001;
    localparam logic [3:0] SEL_SUB  = 4'b0011;
    localparam logic [3:0] SEL_AND  = 4'b0100;
    localparam logic [3:0] SEL_SLL  = 4'b0101;
    localparam logic [3:0] SEL_XOR  = 4'b0110;
    localparam logic [3:0] SEL_NOR  = 4'b0111;
    localparam logic [3:0] SEL_OR   = 4'b1000;
    localparam logic [3:0] SEL_SRL  = 4'b1010;
    localparam logic [3:0] SEL_BEQ  = 4'b1011;
    localparam logic [3:0] SEL_SLT  = 4'b1100;
    localparam logic [3:0] SEL_MUL  = 4'b1101;
    localparam logic [3:0] SEL_DIV  = 4'b1110;
    localparam logic [3:0] SEL_JUMP = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Only mult and div occupy the multi-cycle unit.
    function automatic logic is_multi_funct(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational alu_op/funct decoder producing the ALU select code plus
// illegal / multi-cycle / divide qualifiers.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int FUNCT_W = 6,
    parameter int SEL_W   = 4
) (
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic [SEL_W-1:0]   sel,
    output logic               illegal,
    output logic               is_multi,
    output logic               is_div
);

    logic [3:0] sel4_s;

    // Class decode first; R-type falls through to the funct table.
    always_comb begin
        sel4_s   = SEL_NONE;
        illegal  = 1'b0;
        is_multi = 1'b0;
        is_div   = 1'b0;
        if ((alu_op == ALUOP_W'(OP_LWSW)) || (alu_op == ALUOP_W'(OP_ADDI))) begin
            sel4_s = SEL_ADD;
        end else if (alu_op == ALUOP_W'(OP_BEQ)) begin
            sel4_s = SEL_BEQ;
        end else if (alu_op == ALUOP_W'(OP_JUMP)) begin
            sel4_s = SEL_JUMP;
        end else if (alu_op == ALUOP_W'(OP_RTYPE)) begin
            case (funct)
                FUNCT_W'(FN_ADD):  sel4_s = SEL_ADD;
                FUNCT_W'(FN_SUB):  sel4_s = SEL_SUB;
                FUNCT_W'(FN_AND):  sel4_s = SEL_AND;
                FUNCT_W'(FN_OR):   sel4_s = SEL_OR;
                FUNCT_W'(FN_SLT):  sel4_s = SEL_SLT;
                FUNCT_W'(FN_XOR):  sel4_s = SEL_XOR;
                FUNCT_W'(FN_NOR):  sel4_s = SEL_NOR;
                FUNCT_W'(FN_SLL):  sel4_s = SEL_SLL;
                FUNCT_W'(FN_SRL):  sel4_s = SEL_SRL;
                FUNCT_W'(FN_MULT): begin
                    sel4_s   = SEL_MUL;
                    is_multi = is_multi_funct(FN_MULT);
                end
                FUNCT_W'(FN_DIV): begin
                    sel4_s   = SEL_DIV;
                    is_multi = is_multi_funct(FN_DIV);
                    is_div   = 1'b1;
                end
                default: begin
                    sel4_s  = SEL_NONE;
                    illegal = 1'b1;
                end
            endcase
        end else begin
            illegal = 1'b1;
        end
    end

    assign sel = SEL_W'(sel4_s);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Pipelined ALU control: one registered output stage with valid/ready,
// multi-cycle mult/div sequencing. Optional counters: ALU_CTRL_STATS_EN.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 4,
    parameter int FUNCT_W    = 6,
    parameter int SEL_W      = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   alu_sel,
    output logic               illegal,
    output logic               busy,
    output logic               multi_done,
    output logic [CNT_W-1:0]   op_count,
    output logic [CNT_W-1:0]   illegal_count
);

    localparam int N_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW    = $clog2(N_MAX + 1);

    state_e           state_r;
    logic [CW-1:0]    cnt_r;
    logic [SEL_W-1:0] pend_sel_r;
    logic [SEL_W-1:0] alu_sel_r;
    logic             illegal_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             multi_done_r;

    logic [SEL_W-1:0] dec_sel_s;
    logic             dec_illegal_s;
    logic             dec_multi_s;
    logic             dec_div_s;
    logic             in_ready_s;
    logic             accept_s;

    alu_ctrl_decode #(
        .ALUOP_W (ALUOP_W),
        .FUNCT_W (FUNCT_W),
        .SEL_W   (SEL_W)
    ) u_decode (
        .alu_op   (alu_op),
        .funct    (funct),
        .sel      (dec_sel_s),
        .illegal  (dec_illegal_s),
        .is_multi (dec_multi_s),
        .is_div   (dec_div_s)
    );

    // Ready must follow out_ready combinationally in HOLD for 1/cycle throughput.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == ST_HOLD) begin
            in_ready_s = out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = in_valid && in_ready_s;

    // Pipeline FSM with its output register and multi-cycle countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            pend_sel_r   <= {SEL_W{1'b0}};
            alu_sel_r    <= {SEL_W{1'b0}};
            illegal_r    <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            multi_done_r <= 1'b0;
        end else begin
            multi_done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (accept_s && dec_multi_s) begin
                        // alu_sel keeps its old value until the result is ready.
                        state_r     <= ST_BUSY;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b1;
                        pend_sel_r  <= dec_sel_s;
                        cnt_r       <= dec_div_s ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
                    end else if (accept_s) begin
                        state_r     <= ST_HOLD;
                        out_valid_r <= 1'b1;
                        alu_sel_r   <= dec_sel_s;
                        illegal_r   <= dec_illegal_s;
                    end else if ((state_r == ST_HOLD) && out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == CW'(1)) begin
                        state_r      <= ST_HOLD;
                        out_valid_r  <= 1'b1;
                        busy_r       <= 1'b0;
                        alu_sel_r    <= pend_sel_r;
                        illegal_r    <= 1'b0;
                        multi_done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign alu_sel    = alu_sel_r;
    assign illegal    = illegal_r;
    assign busy       = busy_r;
    assign multi_done = multi_done_r;

`ifdef ALU_CTRL_STATS_EN
    logic [CNT_W-1:0] op_cnt_r;
    logic [CNT_W-1:0] ill_cnt_r;

    // Saturating accept / illegal-accept counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_r  <= {CNT_W{1'b0}};
            ill_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            if (op_cnt_r != {CNT_W{1'b1}}) begin
                op_cnt_r <= op_cnt_r + CNT_W'(1);
            end
            if (dec_illegal_s && (ill_cnt_r != {CNT_W{1'b1}})) begin
                ill_cnt_r <= ill_cnt_r + CNT_W'(1);
            end
        end
    end

    assign op_count      = op_cnt_r;
    assign illegal_count = ill_cnt_r;
`else
    assign op_count      = {CNT_W{1'b0}};
    assign illegal_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_alu_ctrl_pipe;

    localparam int MULN  = 4;
    localparam int DIVN  = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [5:0]       funct;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_sel;
    logic             illegal;
    logic             busy;
    logic             multi_done;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] illegal_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the consumer should see, plus cycles left for a multi op.
    logic       m_valid, m_busy, m_done, m_ill;
    logic [3:0] m_sel, m_pend;
    int         m_rem;
    int         m_ops, m_ills;
    logic [3:0] rtab [logic [5:0]];
    logic [5:0] fn_list [11];

    alu_ctrl_pipe #(
        .ALUOP_W(4), .FUNCT_W(6), .SEL_W(4),
        .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .out_valid(out_valid),
        .out_ready(out_ready), .alu_sel(alu_sel), .illegal(illegal),
        .busy(busy), .multi_done(multi_done), .op_count(op_count),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected decode: {illegal, cycles (0 = single), sel}.
    task automatic ref_dec(input logic [3:0] op, input logic [5:0] f,
                           output logic ill, output int cyc, output logic [3:0] sel);
        ill = 1'b0; cyc = 0; sel = 4'b0000;
        if (op == 4'b0010 || op == 4'b0001) sel = 4'b0001;
        else if (op == 4'b1011) sel = 4'b1011;
        else if (op == 4'b1111) sel = 4'b1111;
        else if (op == 4'b1001 && rtab.exists(f)) begin
            sel = rtab[f];
            if (f == 6'b011000) cyc = MULN;
            if (f == 6'b011010) cyc = DIVN;
        end else ill = 1'b1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ill = 1'b0;
        m_sel = 4'b0000; m_pend = 4'b0000; m_rem = 0; m_ops = 0; m_ills = 0;
    endtask

    // Compare all outputs against the model, advance one clock, update the model.
    task automatic step();
        logic exp_rdy, acc, d_ill;
        int d_cyc;
        logic [3:0] d_sel;
        #1;
        exp_rdy = !rst && !m_busy && (!m_valid || out_ready);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("alu_sel", {28'd0, alu_sel}, {28'd0, m_sel});
        chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("multi_done", {31'd0, multi_done}, {31'd0, m_done});
`ifdef ALU_CTRL_STATS_EN
        chk("op_count", {16'd0, op_count}, 32'(m_ops));
        chk("illegal_count", {16'd0, illegal_count}, 32'(m_ills));
`else
        chk("op_count", {16'd0, op_count}, 32'd0);
        chk("illegal_count", {16'd0, illegal_count}, 32'd0);
`endif
        acc = in_valid && exp_rdy;
        ref_dec(alu_op, funct, d_ill, d_cyc, d_sel);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (acc) begin
                if (m_ops < 65535) m_ops++;
                if (d_ill && m_ills < 65535) m_ills++;
            end
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0; m_valid = 1'b1; m_sel = m_pend; m_ill = 1'b0; m_done = 1'b1;
                end
            end else if (acc && d_cyc != 0) begin
                m_busy = 1'b1; m_valid = 1'b0; m_pend = d_sel; m_rem = d_cyc - 1;
            end else if (acc) begin
                m_valid = 1'b1; m_sel = d_sel; m_ill = d_ill;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] f);
        in_valid = v; alu_op = op; funct = f;
    endtask

    initial begin
        logic       pend;
        int         r;
        rtab[6'b100000] = 4'b0001; rtab[6'b100010] = 4'b0011; rtab[6'b100100] = 4'b0100;
        rtab[6'b100101] = 4'b1000; rtab[6'b101010] = 4'b1100; rtab[6'b100110] = 4'b0110;
        rtab[6'b100111] = 4'b0111; rtab[6'b000000] = 4'b0101; rtab[6'b000010] = 4'b1010;
        rtab[6'b011000] = 4'b1101; rtab[6'b011010] = 4'b1110;
        fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100110,
                    6'b100111, 6'b000000, 6'b000010, 6'b011000, 6'b011010};
        model_reset();

        // Reset
        rst = 1'b1; out_ready = 1'b1; drive(1'b1, 4'b1001, 6'b100000);
        @(posedge clk); #1;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0; drive(1'b0, 4'b0000, 6'b000000);
        step();
        chk("idle_ready", {31'd0, in_ready}, 32'd1);

        // Single sub
        drive(1'b1, 4'b1001, 6'b100010);
        step();
        chk("sub_sel", {28'd0, alu_sel}, 32'h3);
        chk("sub_valid", {31'd0, out_valid}, 32'd1);

        // Back-to-back add, and, slt
        drive(1'b1, 4'b1001, 6'b100000); step(); chk("add_sel", {28'd0, alu_sel}, 32'h1);
        drive(1'b1, 4'b1001, 6'b100100); step(); chk("and_sel", {28'd0, alu_sel}, 32'h4);
        drive(1'b1, 4'b1001, 6'b101010); step(); chk("slt_sel", {28'd0, alu_sel}, 32'hc);

        // Mult: busy for 3 cycles, result + pulse on the 4th
        drive(1'b1, 4'b1001, 6'b011000); step();
        drive(1'b0, 4'b0000, 6'b000000);
        for (int i = 0; i < MULN - 1; i++) begin
            chk("mul_busy", {31'd0, busy}, 32'd1);
            step();
        end
        chk("mul_sel", {28'd0, alu_sel}, 32'hd);
        chk("mul_done", {31'd0, multi_done}, 32'd1);
        step();

        // Illegal class code
        drive(1'b1, 4'b0111, 6'b100000); step();
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_sel", {28'd0, alu_sel}, 32'h0);

        // Backpressure for 3 cycles with a pending op, then release
        out_ready = 1'b0; drive(1'b1, 4'b1001, 6'b100110);
        for (int i = 0; i < 3; i++) step();
        chk("bp_sel_stable", {28'd0, alu_sel}, 32'h0);
        out_ready = 1'b1; step();
        chk("bp_release_sel", {28'd0, alu_sel}, 32'h6);

        // Div aborted by reset mid-count
        drive(1'b1, 4'b1001, 6'b011010); step();
        drive(1'b0, 4'b0000, 6'b000000);
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1; step();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < DIVN; i++) step();
        chk("abort_no_valid", {31'd0, out_valid}, 32'd0);

        // Randomized traffic; an unaccepted request is held stable.
        pend = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!pend) begin
                r = $urandom_range(0, 9);
                if (r <= 5) drive(1'b1, 4'b1001, fn_list[$urandom_range(0, 10)]);
                else if (r == 6) drive(1'b1, 4'b0010, 6'($urandom));
                else if (r == 7) drive(1'b1, 4'b1011, 6'($urandom));
                else if (r == 8) drive(1'b1, 4'b1111, 6'($urandom));
                else drive(1'b1, 4'($urandom), 6'($urandom));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            pend = in_valid && !(!m_busy && (!m_valid || out_ready));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
